// File: rtl/ln_pkg.sv
// ln_pkg: shared constants and the mantissa ROM generator for the fixed-point log unit
package ln_pkg;
  localparam int ACC_W = 32;
  localparam logic [15:0] LN2_Q016 = 16'd45426;
  function automatic int exp_w(input int in_w);
    return $clog2(in_w) + 2;
  endfunction
  // round(ln(1+i/2^aw) * 2^16) via ln(1+x) = 2*atanh(x/(2+x)), evaluated in Q.30 integers
  function automatic logic [15:0] rom_entry(input int i, input int aw);
    longint z, z2, t, s;
    z = (longint'(i) <<< 30) / ((longint'(1) <<< (aw + 1)) + longint'(i));
    z2 = (z * z) >>> 30;
    t = z;
    s = 0;
    for (int k = 0; k < 24; k++) begin
      s = s + t / longint'(2 * k + 1);
      t = (t * z2) >>> 30;
    end
    return 16'(((s <<< 1) + (longint'(1) <<< 13)) >>> 14);
  endfunction
endpackage

// File: rtl/ln_mant_rom.sv
// ln_mant_rom: ln(1+m) table with 2^LUT_AW+1 entries read at addr and addr+1
module ln_mant_rom
  import ln_pkg::*;
#(
  parameter int LUT_AW = 8
) (
  input  logic [LUT_AW-1:0] addr_i,
  output logic [15:0]       y0_o,
  output logic [15:0]       y1_o
);
  logic [15:0] rom [0:(1<<LUT_AW)];
  for (genvar g = 0; g < (1 << LUT_AW); g++) begin : g_rom
    assign rom[g] = rom_entry(g, LUT_AW);
  end
  assign rom[1<<LUT_AW] = LN2_Q016;
  assign y0_o = rom[addr_i];
  assign y1_o = rom[{1'b0, addr_i} + 1'b1];
endmodule

// File: rtl/ln_unit_param.sv
// ln_unit_param: 4-stage elastic fixed-point natural log with tag, zero and saturation flags
module ln_unit_param
  import ln_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int IN_FRAC  = 11,
  parameter int OUT_W    = 16,
  parameter int OUT_FRAC = 8,
  parameter int LUT_AW   = 8,
  parameter int INTERP_W = 2,
  parameter int TAG_W    = 4
) (
  input  logic             iClk,
  input  logic             iRsn,
  input  logic             iValid,
  output logic             oReady,
  input  logic [IN_W-1:0]  iData,
  input  logic [TAG_W-1:0] iTag,
  output logic             oValid,
  input  logic             iReady,
  output logic [OUT_W-1:0] oData,
  output logic [TAG_W-1:0] oTag,
  output logic             oZero,
  output logic             oSat
);
  localparam int MANT_W = LUT_AW + INTERP_W;
  localparam int EW = exp_w(IN_W);
  localparam int MSBW = $clog2(IN_W);
  localparam int SH = 16 - OUT_FRAC;
  localparam logic signed [ACC_W-1:0] LN2_S = ACC_W'(LN2_Q016);
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(longint'(1) << (15 - OUT_FRAC));
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((longint'(1) << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MINV = -MAXV - 1;

  logic v1_q, v2_q, v3_q, v4_q;
  logic rdy1, rdy2, rdy3, rdy4;
  logic [MSBW-1:0] msb;
  logic signed [EW-1:0] exp1_d, exp1_q;
  logic [MANT_W-1:0] mant1_d, mant1_q;
  logic zero1_d, zero1_q, zero2_q, zero3_q;
  logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;
  logic [15:0] y0, y1, y0_q, y1_q;
  logic [INTERP_W-1:0] frac2_q;
  logic signed [ACC_W-1:0] ep2_q, y0_s, y1_s, f_s, acc3_d, acc3_q, r_s;
  logic hi, lo, sat4_d;
  logic [OUT_W-1:0] data4_d;

  assign rdy4 = !v4_q || iReady;
  assign rdy3 = !v3_q || rdy4;
  assign rdy2 = !v2_q || rdy3;
  assign rdy1 = !v1_q || rdy2;
  assign oReady = rdy1;
  assign oValid = v4_q;

  // S1: locate the leading one, derive the exponent and left-aligned mantissa
  always_comb begin
    msb = '0;
    for (int i = 0; i < IN_W; i++) if (iData[i]) msb = MSBW'(i);
    zero1_d = ~|iData;
    exp1_d = zero1_d ? '0 : EW'(msb) - EW'(IN_FRAC);
    mant1_d = MANT_W'(({iData, MANT_W'(0)} << (MSBW'(IN_W - 1) - msb)) >> (IN_W - 1));
  end

  ln_mant_rom #(.LUT_AW(LUT_AW)) u_rom (
    .addr_i(mant1_q[MANT_W-1:INTERP_W]),
    .y0_o  (y0),
    .y1_o  (y1)
  );

  // S3 interpolation between adjacent ROM entries plus the exponent term
  always_comb begin
    y0_s = ACC_W'(y0_q);
    y1_s = ACC_W'(y1_q);
    f_s = ACC_W'(frac2_q);
    acc3_d = ep2_q + y0_s + (((y1_s - y0_s) * f_s) >>> INTERP_W);
  end

  // S4 round half-up to the output grid, clamp, and encode the zero-input result
  always_comb begin
    r_s = (acc3_q + RND) >>> SH;
    hi = r_s > MAXV;
    lo = r_s < MINV;
    data4_d = zero3_q ? OUT_W'(MINV) : hi ? OUT_W'(MAXV) : lo ? OUT_W'(MINV) : OUT_W'(r_s);
    sat4_d = !zero3_q && (hi || lo);
  end

  // datapath registers of S1..S3 advance only on a handshake and hold while stalled
  always_ff @(posedge iClk) begin
    if (rdy1 && iValid) begin
      exp1_q <= exp1_d;
      mant1_q <= mant1_d;
      zero1_q <= zero1_d;
      tag1_q <= iTag;
    end
    if (rdy2 && v1_q) begin
      y0_q <= y0;
      y1_q <= y1;
      frac2_q <= mant1_q[INTERP_W-1:0];
      ep2_q <= ACC_W'(exp1_q) * LN2_S;
      zero2_q <= zero1_q;
      tag2_q <= tag1_q;
    end
    if (rdy3 && v2_q) begin
      acc3_q <= acc3_d;
      zero3_q <= zero2_q;
      tag3_q <= tag2_q;
    end
  end

  // stage valids and the visible output register, cleared by reset
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      {v1_q, v2_q, v3_q, v4_q} <= '0;
      oData <= '0;
      oTag <= '0;
      oZero <= 1'b0;
      oSat <= 1'b0;
    end else begin
      if (rdy1) v1_q <= iValid;
      if (rdy2) v2_q <= v1_q;
      if (rdy3) v3_q <= v2_q;
      if (rdy4) v4_q <= v3_q;
      if (rdy4 && v3_q) begin
        oData <= data4_d;
        oTag <= tag3_q;
        oZero <= zero3_q;
        oSat <= sat4_d;
      end
    end
  end
endmodule

// File: doc/ln_unit_param.md
Name: ln_unit_param

Overview:
Parametrised fixed-point natural-log unit; successor of the 4-stage Q5.11→Q7.8 log block in the softmax datapath.
- Input format, output format, mantissa LUT depth and interpolation width are generics.
- Adds: sideband tag passthrough, explicit zero-input flag, output saturation flag, and an (N+1)-entry mantissa ROM so the top interval needs no boundary clamp.
- Sits between the exp-sum accumulator and the log-subtract stage of the softmax layer.

Parameters:
IN_W, 16, input width (unsigned), 2..32
IN_FRAC, 11, input fractional bits, 0..IN_W-1
OUT_W, 16, output width (signed two's complement)
OUT_FRAC, 8, output fractional bits, 0..15
LUT_AW, 8, mantissa ROM address bits (ROM holds 2^LUT_AW+1 entries)
INTERP_W, 2, interpolation fraction bits; MANT_W = LUT_AW+INTERP_W
TAG_W, 4, sideband tag width, ≥1

Ports:
iClk  in  1  clock, all state on rising edge
iRsn  in  1  asynchronous active-low reset
iValid  in  1  input valid
oReady  out  1  input ready
iData  in  IN_W  unsigned Q(IN_W-IN_FRAC).IN_FRAC operand
iTag  in  TAG_W  sideband, carried unchanged
oValid  out  1  output valid
iReady  in  1  downstream ready
oData  out  OUT_W  signed Q(OUT_W-OUT_FRAC).OUT_FRAC result, ln(iData)
oTag  out  TAG_W  tag of the item on oData
oZero  out  1  item was iData==0
oSat  out  1  result was clamped

Behaviour:
- Reset (async assert, sync release): all 4 stage valids = 0; oValid=0; oData, oTag, oZero, oSat = 0. Datapath regs need not reset.
- Pipeline: 4 elastic stages.
  - Stage k ready = !validk || ready(k+1); stage 4 uses iReady; oReady = stage-1 ready.
  - Transfer on valid&&ready at each boundary; a stalled stage holds data, tag and flags.
  - Latency 4 cycles with no stall; throughput 1/cycle.
  - No combinational path iValid→oValid. The combinational iReady→oReady chain is accepted.
- S1 normalise:
  - msb = index of highest 1 in iData; exp = msb - IN_FRAC (signed).
  - Left-align iData so msb sits at bit IN_W-1; mant = next MANT_W bits below it, zero-filled if fewer exist.
  - Zero input: set zero flag, force exp=0, mant=0.
- S2 lookup:
  - addr = mant[MANT_W-1:INTERP_W]; y0 = ROM[addr], y1 = ROM[addr+1]. ROM[i] = round(ln(1+i/2^LUT_AW)·2^16), unsigned Q0.16; ROM[2^LUT_AW] = LN2_Q016.
  - Register the product exp·LN2_Q016 (signed, 32-bit accumulator domain Q.16).
- S3 sum:
  - interp = y0 + ((y1-y0)·frac) >>> INTERP_W, where frac = mant[INTERP_W-1:0].
  - acc = exp·LN2 + interp, 32-bit signed.
- S4 output:
  - Round half-up: r = (acc + 2^(15-OUT_FRAC)) >>> (16-OUT_FRAC).
  - If r > 2^(OUT_W-1)-1 or r < -2^(OUT_W-1): clamp and set oSat=1.
  - Zero flag: oData = -2^(OUT_W-1), oZero=1, oSat=0.
- Tag and flags travel with the data through every stage.
- Reset mid-stream: in-flight items discarded, no output until fresh input.
- iValid high while oReady low: the item is neither lost nor duplicated. Simultaneous stage-4 drain and stage-1 fill in one cycle is legal.

Decomposition:
- Package ln_pkg:
  - LN2_Q016 = 45426
  - Q0.16 ROM-entry function/constant generator
  - ACC_W = 32
  - exp signed width = $clog2(IN_W)+2
- Sub-module ln_mant_rom: combinational, 2 read ports, 2^LUT_AW+1 entries. The top entry removes the boundary clamp.
- Priority encoder stays inline; it is a single loop.

Test Plan:
- Defaults, iData=0x0800 (1.0) -> oData=0x0000 after 4 cycles, oZero=0, oSat=0.
- iData 0x1000 / 0x1800 / 0x0001 / 0xFFFF back-to-back, tags 1..4 -> oData 0x00B1 / 0x0119 / 0xF860 / 0x0377 on consecutive cycles, oTag 1..4.
- iData=0x0000, tag 7 -> oData=0x8000, oZero=1, oTag=7.
- Random stream with iReady toggling 50%, plus iReady held low 10 cycles -> oReady low once the pipeline is full; output sequence and tags identical to the no-stall run; no drops or duplicates.
- OUT_W=8, OUT_FRAC=6, iData=0xFFFF (IN_FRAC=11) -> ln≈3.466 exceeds 1.98 -> oData=0x7F, oSat=1.
- Assert iRsn low with 3 items in flight -> oValid=0 immediately; after release, no output until new input; next item 0x0800 -> 0x0000.
